// File: rtl/datapath_ls.sv
// Multi-cycle load/store/add-immediate datapath: register file, word-addressed data memory,
// and a four-state controller (IDLE -> EXEC -> [MEM] -> WB).
module datapath_ls #(
    parameter int WIDTH     = 64,
    parameter int NREG      = 32,
    parameter int MEM_DEPTH = 32,
    localparam int RW       = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [RW-1:0]    a,
    input  logic [RW-1:0]    b,
    input  logic [RW-1:0]    w,
    input  logic [WIDTH-1:0] imm,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] MEM  = 2'd2;
    localparam logic [1:0] WB   = 2'd3;

    localparam logic [1:0] OP_STORE = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_ADDI  = 2'b10;

    logic [1:0]       state;
    logic [1:0]       op_q;
    logic [RW-1:0]    a_q;
    logic [RW-1:0]    b_q;
    logic [RW-1:0]    w_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] data_q;
    logic             err_q;

    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] mem  [MEM_DEPTH];

    logic [WIDTH-1:0] sum;
    logic             in_range;
    logic [AW-1:0]    mem_idx;

    // The effective address and the ADDI result are the same sum, so addr_q serves both.
    always_comb begin
        sum      = imm_q + regs[b_q];
        in_range = (sum < WIDTH'(MEM_DEPTH));
        mem_idx  = addr_q[AW-1:0];
    end

    assign rdata_a = (a == '0) ? '0 : regs[a];
    assign rdata_b = (b == '0) ? '0 : regs[b];

    assign busy = (state != IDLE);
    assign done = (state == WB);
    assign err  = (state == WB) && err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            w_q    <= '0;
            imm_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= WIDTH'(i);
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        w_q   <= w;
                        imm_q <= imm;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    addr_q <= sum;
                    err_q  <= 1'b0;
                    case (op_q)
                        OP_STORE, OP_LOAD: begin
                            if (in_range) begin
                                state <= MEM;
                            end else begin
                                err_q <= 1'b1;
                                state <= WB;
                            end
                        end
                        OP_ADDI: state <= WB;
                        default: begin
                            err_q <= 1'b1;
                            state <= WB;
                        end
                    endcase
                end
                MEM: begin
                    if (op_q == OP_LOAD) begin
                        data_q <= mem[mem_idx];
                    end
                    state <= WB;
                end
                default: begin
                    if (!err_q && (w_q != '0)) begin
                        if (op_q == OP_LOAD) begin
                            regs[w_q] <= data_q;
                        end else if (op_q == OP_ADDI) begin
                            regs[w_q] <= addr_q;
                        end
                    end
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory has no reset; an asynchronous reset drops state out of MEM, cancelling any write.
    always_ff @(posedge clk) begin
        if ((state == MEM) && (op_q == OP_STORE)) begin
            mem[mem_idx] <= regs[a_q];
        end
    end

endmodule

// File: tb/tb_datapath_ls.sv
// Directed self-checking bench for datapath_ls: reset values, STORE/LOAD/ADDI, latency,
// error paths, ignored start while busy, and reset during an in-flight LOAD.
module tb_datapath_ls;

    localparam int WIDTH = 64;
    localparam int NREG  = 32;
    localparam int RW    = 5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [RW-1:0]    a;
    logic [RW-1:0]    b;
    logic [RW-1:0]    w;
    logic [WIDTH-1:0] imm;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;

    int n_checks;
    int n_fail;

    datapath_ls #(.WIDTH(WIDTH), .NREG(NREG), .MEM_DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .w(w), .imm(imm),
        .busy(busy), .done(done), .err(err), .rdata_a(rdata_a), .rdata_b(rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op; a is switched to the destination index after accept so rdata_a tracks reg[w].
    // With poke set, an ADDI w=9 request is held on the inputs for the whole busy period.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [RW-1:0] ia,
                         input logic [RW-1:0] ib, input logic [RW-1:0] iw,
                         input logic [WIDTH-1:0] iimm, input int exp_n, input logic exp_err,
                         input logic [WIDTH-1:0] exp_old, input logic [WIDTH-1:0] exp_new,
                         input bit poke);
        int cnt;
        start = 1'b1; op = o; a = ia; b = ib; w = iw; imm = iimm;
        @(posedge clk); #1;
        a = iw;
        if (poke) begin
            op = 2'b10; w = 5'd9; b = '0; imm = 64'd5;
        end else begin
            start = 1'b0;
        end
        cnt = 0;
        while (!done && cnt < 8) begin
            @(posedge clk); #1;
            cnt++;
        end
        start = 1'b0;
        check({tag, ".latency"}, 64'(cnt), 64'(exp_n));
        check({tag, ".done"}, 64'(done), 64'd1);
        check({tag, ".err"}, 64'(err), 64'(exp_err));
        check({tag, ".busy_wb"}, 64'(busy), 64'd1);
        check({tag, ".old_in_wb"}, rdata_a, exp_old);
        @(posedge clk); #1;
        check({tag, ".done_clr"}, 64'(done), 64'd0);
        check({tag, ".err_clr"}, 64'(err), 64'd0);
        check({tag, ".idle"}, 64'(busy), 64'd0);
        check({tag, ".new"}, rdata_a, exp_new);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; start = 1'b0; op = '0; a = 5'd2; b = 5'd31; w = '0; imm = '0;
        #12;
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.err", 64'(err), 64'd0);
        check("rst.rdata_a", rdata_a, 64'd2);
        check("rst.rdata_b", rdata_b, 64'd31);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // STORE mem[8] = reg[4]; w is unused so rdata_a just tracks reg[20]
        do_op("store", 2'b00, 5'd4, 5'd6, 5'd20, 64'd2, 2, 1'b0, 64'd20, 64'd20, 1'b0);
        do_op("load31", 2'b01, 5'd0, 5'd0, 5'd31, 64'd8, 2, 1'b0, 64'd31, 64'd4, 1'b0);
        do_op("addi3", 2'b10, 5'd0, 5'd21, 5'd3, 64'd10, 1, 1'b0, 64'd3, 64'd31, 1'b0);
        do_op("addi_wrap", 2'b10, 5'd0, 5'd2, 5'd7, '1, 1, 1'b0, 64'd7, 64'd1, 1'b0);
        do_op("load_oob", 2'b01, 5'd0, 5'd13, 5'd2, 64'd30, 1, 1'b1, 64'd2, 64'd2, 1'b0);
        do_op("op11", 2'b11, 5'd1, 5'd0, 5'd6, 64'd0, 1, 1'b1, 64'd6, 64'd6, 1'b0);

        do_op("load_busy", 2'b01, 5'd0, 5'd0, 5'd10, 64'd8, 2, 1'b0, 64'd10, 64'd4, 1'b1);
        a = 5'd9;
        #1;
        check("ignored.reg9", rdata_a, 64'd9);
        @(posedge clk); #1;
        check("ignored.no_accept", 64'(busy), 64'd0);

        do_op("load_r0", 2'b01, 5'd0, 5'd0, 5'd0, 64'd8, 2, 1'b0, 64'd0, 64'd0, 1'b0);

        // Reset asserted while the LOAD to reg[5] is in MEM
        start = 1'b1; op = 2'b01; a = 5'd5; b = '0; w = 5'd5; imm = 64'd8;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("mid.busy_mem", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid.busy", 64'(busy), 64'd0);
        check("mid.done", 64'(done), 64'd0);
        check("mid.reg5", rdata_a, 64'd5);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("mid.no_done", 64'(done), 64'd0);
        end
        a = 5'd31;
        #1;
        check("mid.reg31", rdata_a, 64'd31);
        rst_n = 1'b1;
        @(posedge clk); #1;
        a = 5'd5;
        #1;
        check("post.reg5", rdata_a, 64'd5);
        do_op("load_persist", 2'b01, 5'd0, 5'd0, 5'd12, 64'd8, 2, 1'b0, 64'd12, 64'd4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
